// File: rtl/mano_core_param.sv
// mano_core_param: parametrised Mano accumulator CPU with on-chip program memory.
// Define MANO_STEP_EN to add a `step` input that gates each instruction at T0.
module mano_core_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef MANO_STEP_EN
    input  logic              step,
`endif
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [DATA_W-1:0] acc,
    output logic              e_flag,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        tstate,
    output logic              halted
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        IDLE = 3'd7
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] acc_q;
    logic              e_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] mar_q;
    logic [DATA_W-1:0] mbr_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              adv;
    logic [7:0]        op_hot;
    logic [DATA_W:0]   sum_m;
    logic [DATA_W:0]   sum_1;
    logic              unused_ir;

    logic ld_mar_pc;
    logic ld_mbr;
    logic inc_pc;
    logic ld_ir;
    logic ld_mar_addr;
    logic mem_wr;
    logic jmp;
    logic alu_cma;
    logic alu_inc;
    logic ld_a_m;
    logic add_m;
    logic and_m;

`ifdef MANO_STEP_EN
    assign adv = step;
`else
    assign adv = 1'b1;
`endif

    assign op_hot    = 8'd1 << ir_q[DATA_W-1 -: 3];
    assign sum_m     = {1'b0, acc_q} + {1'b0, mbr_q};
    assign sum_1     = {1'b0, acc_q} + 1'b1;
    // Middle IR bits carry no meaning; fold them away explicitly.
    assign unused_ir = ^ir_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ld_mar_pc   = 1'b0;
        ld_mbr      = 1'b0;
        inc_pc      = 1'b0;
        ld_ir       = 1'b0;
        ld_mar_addr = 1'b0;
        mem_wr      = 1'b0;
        jmp         = 1'b0;
        alu_cma     = 1'b0;
        alu_inc     = 1'b0;
        ld_a_m      = 1'b0;
        add_m       = 1'b0;
        and_m       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = T0;
                end
            end
            T0: begin
                if (adv) begin
                    ld_mar_pc = 1'b1;
                    state_d   = T1;
                end
            end
            T1: begin
                ld_mbr  = 1'b1;
                inc_pc  = 1'b1;
                state_d = T2;
            end
            T2: begin
                ld_ir       = 1'b1;
                ld_mar_addr = 1'b1;
                state_d     = T3;
            end
            T3: begin
                state_d = T0;
                unique case (1'b1)
                    op_hot[0], op_hot[1], op_hot[2]: begin
                        ld_mbr  = 1'b1;
                        state_d = T4;
                    end
                    op_hot[3]: mem_wr  = 1'b1;
                    op_hot[4]: jmp     = 1'b1;
                    op_hot[5]: alu_cma = 1'b1;
                    op_hot[6]: alu_inc = 1'b1;
                    op_hot[7]: state_d = IDLE;
                    default:   state_d = T0;
                endcase
            end
            T4: begin
                ld_a_m  = op_hot[0];
                add_m   = op_hot[1];
                and_m   = op_hot[2];
                state_d = T0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            e_q   <= 1'b0;
            pc_q  <= '0;
            mar_q <= '0;
            mbr_q <= '0;
            ir_q  <= '0;
        end else begin
            if (ld_mar_pc) begin
                mar_q <= pc_q;
            end
            if (ld_mar_addr) begin
                mar_q <= mbr_q[ADDR_W-1:0];
            end
            if (ld_mbr) begin
                mbr_q <= mem[mar_q];
            end
            if (ld_ir) begin
                ir_q <= mbr_q;
            end
            if (inc_pc) begin
                pc_q <= pc_q + 1'b1;
            end
            // MAR already holds the address field by T3.
            if (jmp) begin
                pc_q <= mar_q;
            end
            unique case (1'b1)
                ld_a_m:  acc_q <= mbr_q;
                add_m:   {e_q, acc_q} <= sum_m;
                and_m:   acc_q <= acc_q & mbr_q;
                alu_cma: acc_q <= ~acc_q;
                alu_inc: {e_q, acc_q} <= sum_1;
                default: acc_q <= acc_q;
            endcase
        end
    end

    // Memory survives reset; only the write strobes are blocked by it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (mem_wr) begin
                mem[mar_q] <= acc_q;
            end else if (state_q == IDLE && prog_we) begin
                mem[prog_addr] <= prog_wdata;
            end
        end
    end

    assign dbg_rdata = mem[prog_addr];
    assign acc       = acc_q;
    assign e_flag    = e_q;
    assign pc        = pc_q;
    assign tstate    = state_q;
    assign halted    = (state_q == IDLE);

endmodule

// File: tb/tb_mano_core_param.sv
// tb_mano_core_param: vector table, directed sequences and random programs
// checked against an instruction-level model of the Mano core.
module tb_mano_core_param;

    logic       clk;
    logic       rst;
    logic       start;
`ifdef MANO_STEP_EN
    logic       step;
`endif
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_wdata;
    logic [7:0] dbg_rdata;
    logic [7:0] acc;
    logic       e_flag;
    logic [3:0] pc;
    logic [2:0] tstate;
    logic       halted;

    int checks;
    int failures;

    mano_core_param #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
`ifdef MANO_STEP_EN
        .step       (step),
`endif
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .dbg_rdata  (dbg_rdata),
        .acc        (acc),
        .e_flag     (e_flag),
        .pc         (pc),
        .tstate     (tstate),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] a_init;
        logic [7:0] opw;
        logic [7:0] m;
        logic [7:0] exp_acc;
        logic       exp_e;
        logic [7:0] exp_m15;
        logic [3:0] exp_pc;
        int         exp_cyc;
    } vec_t;

    vec_t vecs [10];

    // Instruction-level reference model.
    logic [7:0] m_a;
    logic       m_e;
    logic [3:0] m_pc;
    logic [7:0] m_mem [16];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        prog_we    = 1'b1;
        prog_addr  = a;
        prog_wdata = d;
        @(posedge clk);
        #1 prog_we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        prog_addr = a;
        @(negedge clk);
        d = dbg_rdata;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_prog(input logic we, input logic [3:0] a,
                            input logic [7:0] d, input int budget,
                            output int cyc);
        start      = 1'b1;
        prog_we    = we;
        prog_addr  = a;
        prog_wdata = d;
        @(posedge clk);
        #1;
        start   = 1'b0;
        prog_we = 1'b0;
        cyc = 0;
        while (!halted && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic model_run(output int cyc, output bit ok);
        logic [7:0] w;
        logic [3:0] ad;
        cyc = 0;
        ok  = 1'b0;
        for (int n = 0; n < 64 && !ok; n++) begin
            w    = m_mem[m_pc];
            m_pc = m_pc + 4'd1;
            ad   = w[3:0];
            case (w[7:5])
                3'd0: begin m_a = m_mem[ad]; cyc += 5; end
                3'd1: begin
                    {m_e, m_a} = {1'b0, m_a} + {1'b0, m_mem[ad]};
                    cyc += 5;
                end
                3'd2: begin m_a = m_a & m_mem[ad]; cyc += 5; end
                3'd3: begin m_mem[ad] = m_a; cyc += 4; end
                3'd4: begin m_pc = ad; cyc += 4; end
                3'd5: begin m_a = ~m_a; cyc += 4; end
                3'd6: begin {m_e, m_a} = {1'b0, m_a} + 9'd1; cyc += 4; end
                default: begin cyc += 4; ok = 1'b1; end
            endcase
        end
    endtask

    initial begin
        int         cyc;
        int         n;
        int         ecyc;
        int         accepted;
        bit         ok;
        logic [7:0] d;
        logic [7:0] prog [16];
        logic [7:0] sa;
        logic       se;
        logic [3:0] sp;
        logic [31:0] w;

        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        start      = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_wdata = '0;
`ifdef MANO_STEP_EN
        step       = 1'b1;
`endif

        vecs[0] = '{8'h12, 8'h0F, 8'h34, 8'h34, 1'b0, 8'h34, 4'd3, 14};
        vecs[1] = '{8'h80, 8'h2F, 8'h7F, 8'hFF, 1'b0, 8'h7F, 4'd3, 14};
        vecs[2] = '{8'hC0, 8'h2F, 8'h50, 8'h10, 1'b1, 8'h50, 4'd3, 14};
        vecs[3] = '{8'hF0, 8'h4F, 8'h3C, 8'h30, 1'b0, 8'h3C, 4'd3, 14};
        vecs[4] = '{8'h5A, 8'h6F, 8'h00, 8'h5A, 1'b0, 8'h5A, 4'd3, 13};
        vecs[5] = '{8'h11, 8'h8F, 8'hE0, 8'h11, 1'b0, 8'hE0, 4'd0, 13};
        vecs[6] = '{8'h3C, 8'hAF, 8'h99, 8'hC3, 1'b0, 8'h99, 4'd3, 13};
        vecs[7] = '{8'h7F, 8'hCF, 8'h00, 8'h80, 1'b0, 8'h00, 4'd3, 13};
        vecs[8] = '{8'hFF, 8'hCF, 8'h00, 8'h00, 1'b1, 8'h00, 4'd3, 13};
        vecs[9] = '{8'h42, 8'hE0, 8'h66, 8'h42, 1'b0, 8'h66, 4'd2, 9};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_acc", 32'(acc), 32'h0);
        chk("rst_e", 32'(e_flag), 32'h0);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_tstate", 32'(tstate), 32'd7);
        chk("rst_halted", 32'(halted), 32'd1);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_beats_start", 32'(tstate), 32'd7);
        start = 1'b0;
        rst   = 1'b0;

        // Single-instruction table.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            load(4'd0, 8'h0E);
            load(4'd14, vecs[i].a_init);
            load(4'd1, vecs[i].opw);
            load(4'd15, vecs[i].m);
            load(4'd2, 8'hE0);
            run_prog(1'b0, 4'd0, 8'h00, 40, cyc);
            chk($sformatf("vec%0d_cyc", i), 32'(cyc), 32'(vecs[i].exp_cyc));
            chk($sformatf("vec%0d_acc", i), 32'(acc), 32'(vecs[i].exp_acc));
            chk($sformatf("vec%0d_e", i), 32'(e_flag), 32'(vecs[i].exp_e));
            chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
            rd(4'd15, d);
            chk($sformatf("vec%0d_m15", i), 32'(d), 32'(vecs[i].exp_m15));
        end

        // Reference program; mem[0] written in the same cycle as start.
        do_reset();
        load(4'd0, 8'hE0);
        load(4'd1, 8'h29);
        load(4'd2, 8'h6A);
        load(4'd3, 8'hE0);
        load(4'd8, 8'h05);
        load(4'd9, 8'h07);
        run_prog(1'b1, 4'd0, 8'h08, 40, cyc);
        chk("prog_cycles", 32'(cyc), 32'd18);
        chk("prog_acc", 32'(acc), 32'h0C);
        chk("prog_e", 32'(e_flag), 32'h0);
        chk("prog_pc", 32'(pc), 32'd4);
        rd(4'd10, d);
        chk("prog_m10", 32'(d), 32'h0C);

        // Carry, with a write attempt during T2 that must be dropped.
        do_reset();
        load(4'd0, 8'h08);
        load(4'd1, 8'h29);
        load(4'd2, 8'hE0);
        load(4'd8, 8'hFF);
        load(4'd9, 8'h01);
        load(4'd15, 8'h11);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (tstate != 3'd2 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("guard_in_t2", 32'(tstate), 32'd2);
        load(4'd15, 8'h99);
        n = 0;
        while (!halted && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("carry_halted", 32'(halted), 32'd1);
        chk("carry_acc", 32'(acc), 32'h00);
        chk("carry_e", 32'(e_flag), 32'h1);
        rd(4'd15, d);
        chk("guard_m15", 32'(d), 32'h11);
        load(4'd3, 8'hC0);
        load(4'd4, 8'hE0);
        run_prog(1'b0, 4'd0, 8'h00, 40, cyc);
        chk("inc_cycles", 32'(cyc), 32'd8);
        chk("inc_acc", 32'(acc), 32'h01);
        chk("inc_e", 32'(e_flag), 32'h0);
        chk("inc_pc", 32'(pc), 32'd5);

        // CMA at 15, PC wrap, JMP, HLT.
        do_reset();
        load(4'd0, 8'h8D);
        load(4'd13, 8'h0C);
        load(4'd12, 8'h0F);
        load(4'd14, 8'hE0);
        run_prog(1'b0, 4'd0, 8'h00, 40, cyc);
        chk("wrap_setup_pc", 32'(pc), 32'd15);
        chk("wrap_setup_acc", 32'(acc), 32'h0F);
        load(4'd15, 8'hA0);
        load(4'd0, 8'h84);
        load(4'd4, 8'hE0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("wrap_pc0", 32'(pc), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("wrap_cma_acc", 32'(acc), 32'hF0);
        n = 0;
        while (!halted && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wrap_tail_cycles", 32'(n), 32'd8);
        chk("wrap_pc", 32'(pc), 32'd5);
        chk("wrap_acc", 32'(acc), 32'hF0);

        // Reset during T3 of STA.
        do_reset();
        load(4'd0, 8'h08);
        load(4'd1, 8'h6A);
        load(4'd8, 8'h33);
        load(4'd10, 8'h55);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (!(pc == 4'd2 && tstate == 3'd3) && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("midrst_in_t3", 32'(tstate), 32'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_tstate", 32'(tstate), 32'd7);
        chk("midrst_acc", 32'(acc), 32'h0);
        chk("midrst_pc", 32'(pc), 32'd0);
        rst = 1'b0;
        rd(4'd10, d);
        chk("midrst_m10", 32'(d), 32'h55);
        rd(4'd8, d);
        chk("midrst_m8", 32'(d), 32'h33);
        rd(4'd0, d);
        chk("midrst_m0", 32'(d), 32'h08);

        // Random programs against the model.
        do_reset();
        m_a  = 8'h00;
        m_e  = 1'b0;
        m_pc = 4'd0;
        accepted = 0;
        for (int t = 0; t < 300 && accepted < 20; t++) begin
            for (int i = 0; i < 16; i++) begin
                w       = $urandom;
                prog[i] = w[7:0];
                m_mem[i] = w[7:0];
            end
            sa = m_a;
            se = m_e;
            sp = m_pc;
            model_run(ecyc, ok);
            if (!ok) begin
                m_a  = sa;
                m_e  = se;
                m_pc = sp;
            end else begin
                accepted++;
                for (int i = 0; i < 16; i++) begin
                    load(4'(i), prog[i]);
                end
                run_prog(1'b0, 4'd0, 8'h00, ecyc + 10, cyc);
                chk($sformatf("rnd%0d_cyc", t), 32'(cyc), 32'(ecyc));
                chk($sformatf("rnd%0d_acc", t), 32'(acc), 32'(m_a));
                chk($sformatf("rnd%0d_e", t), 32'(e_flag), 32'(m_e));
                chk($sformatf("rnd%0d_pc", t), 32'(pc), 32'(m_pc));
                for (int i = 0; i < 16; i++) begin
                    rd(4'(i), d);
                    chk($sformatf("rnd%0d_m%0d", t, i), 32'(d), 32'(m_mem[i]));
                end
            end
        end
        chk("rnd_accepted", 32'(accepted), 32'd20);

`ifdef MANO_STEP_EN
        do_reset();
        load(4'd0, 8'h08);
        load(4'd1, 8'h29);
        load(4'd2, 8'h6A);
        load(4'd3, 8'hE0);
        load(4'd8, 8'h05);
        load(4'd9, 8'h07);
        step  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("step_hold_t", 32'(tstate), 32'd0);
        chk("step_hold_pc", 32'(pc), 32'd0);
        for (int p = 1; p <= 4; p++) begin
            step = 1'b1;
            @(posedge clk);
            #1 step = 1'b0;
            n = 0;
            while (tstate != 3'd0 && !halted && n < 10) begin
                @(posedge clk);
                #1;
                n++;
            end
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("step%0d_pc", p), 32'(pc), 32'(p));
            chk($sformatf("step%0d_halted", p), 32'(halted), 32'(p == 4));
            chk($sformatf("step%0d_acc", p), 32'(acc),
                (p == 1) ? 32'h05 : 32'h0C);
        end
        step = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mano_core_param.md
# mano_core_param

Parametrised successor to the fixed 8-bit Mano teaching computer: a single-clock accumulator CPU with configurable data and address widths. It holds its own program/data memory, which is loaded through a load port while the core is idle. It then runs a fixed fetch/decode/execute timing sequence T0–T4 until it executes HLT. The block sits directly under the TinyTapeout top wrapper, which maps its status outputs onto `uo_out`/`uio_out`.

## Interface
- `DATA_W`, 8: accumulator, MBR, IR and memory word width; must be ≥ `ADDR_W`+3.
- `ADDR_W`, 4: PC/MAR width; memory depth is 2**`ADDR_W` words.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; leaves IDLE and begins fetch at the current PC.
- `prog_we` in 1: memory write strobe; honoured only in IDLE.
- `prog_addr` in `ADDR_W`: load/debug address.
- `prog_wdata` in `DATA_W`: load data.
- `dbg_rdata` out `DATA_W`: combinational read, `mem[prog_addr]`.
- `acc` out `DATA_W`: accumulator A.
- `e_flag` out 1: carry flag E.
- `pc` out `ADDR_W`: program counter.
- `tstate` out 3: current timing state (0–4 = T0–T4, 7 = IDLE).
- `halted` out 1: high in IDLE.

## Operation
- Instruction word fields:
  - opcode = bits [`DATA_W`-1 : `DATA_W`-3].
  - address = bits [`ADDR_W`-1:0].
  - Remaining bits are ignored.
- Opcodes:
  - 000 LDA: A←M.
  - 001 ADD: {E,A}←A+M.
  - 010 AND: A←A&M.
  - 011 STA: M←A.
  - 100 JMP: PC←addr.
  - 101 CMA: A←~A.
  - 110 INC: {E,A}←A+1.
  - 111 HLT.
- Timing states:
  - T0: MAR←PC.
  - T1: MBR←mem[MAR]; PC←PC+1.
  - T2: IR←MBR; MAR←address field.
  - T3:
    - LDA/ADD/AND: MBR←mem[MAR], go to T4.
    - STA: mem[MAR]←A.
    - JMP: PC←addr.
    - CMA/INC: ALU op.
    - Then T0, except HLT, which goes to IDLE.
  - T4: A (and E for ADD) updated from MBR; go to T0.
- IDLE:
  - Entered on reset and on HLT.
  - `prog_we` writes `prog_wdata` to `mem[prog_addr]`.
  - `start` moves to T0.
  - `start` outside IDLE is ignored.
  - `prog_we` outside IDLE is ignored, and memory is unchanged.
- Arithmetic:
  - All arithmetic is modulo 2**`DATA_W`; the carry out goes to E.
  - LDA, AND and CMA leave E unchanged.
  - PC increments modulo 2**`ADDR_W` (wraps from all-ones to 0).

## Timing
- Reset values: A, E, PC, MAR, MBR and IR = 0; `tstate`=7; `halted`=1.
- Memory is not cleared by reset.
- Reset wins over every other input in the same cycle, including mid-instruction. The next cycle is IDLE with the reset values.
- `start` sampled high in IDLE → T0 on the next cycle, and `halted` falls that cycle.
- Same-cycle `prog_we` and `start` in IDLE: the write is performed and the start is taken. The first fetch observes the new data.
- Instruction latencies:
  - LDA/ADD/AND: 5 cycles.
  - STA/JMP/CMA/INC: 4 cycles.
  - HLT: 4 cycles; `halted` is high on the cycle after its T3.
- STA followed by a fetch of the same address returns the stored value.

## Configuration
- `MANO_STEP_EN` defined:
  - Adds input `step` (1 bit).
  - The core holds in T0, with no register changes, until `step` is sampled high; it then proceeds through the instruction.
  - Exactly one instruction executes per `step` pulse.
  - `step` held high runs freely.
  - `step` has no effect in IDLE.
- `MANO_STEP_EN` undefined: the `step` port is absent, and T0 never stalls.

## Test plan
All scenarios use `DATA_W`=8, `ADDR_W`=4.
- Program run:
  - Load mem[0..3] = 0x08, 0x29, 0x6A, 0xE0 and mem[8]=0x05, mem[9]=0x07; pulse `start`.
  - Expect `halted` high exactly 18 cycles after `start` (5+5+4+4).
  - Expect `acc`=0x0C, `e_flag`=0, mem[10]=0x0C (read via `dbg_rdata`), `pc`=4.
- Carry:
  - LDA of 0xFF, then ADD of 0x01.
  - Expect `acc`=0x00, `e_flag`=1; a following INC gives `acc`=0x01, `e_flag`=0.
- CMA/JMP/wrap:
  - mem[15]=0xA0 (CMA), mem[0]=0x84 (JMP 4), mem[4]=0xE0 (HLT); A=0x0F; start with PC=15.
  - Expect `pc` wraps 15→0, `acc`=0xF0, then halt with `pc`=5.
- Reset mid-op:
  - Assert `rst` during T3 of an STA.
  - Expect the target word unchanged, `acc`=0, `pc`=0, `tstate`=7.
  - Previously loaded memory words are intact.
- Load guard: `prog_we` pulsed while in T2 → memory is unchanged.
- Step mode (`MANO_STEP_EN`):
  - Run the first program with `step` low: `tstate` stays 0 with `pc`=0.
  - Each `step` pulse completes exactly one instruction; the fourth pulse halts.
